mem_arb: RTL

//  Two-master to one-slave memory arbiter directly downstream of the processor core.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arb_pick.sv | 34 +++
 rtl/mem_arb.sv | 129 ++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-master memory arbiter.
// Contents: data-path widths, FSM state enum, master index enum.
// No logic; imported by mem_arb and mem_arb_pick.
package mem_arb_pkg;

  // Pipeline word width; address and data paths follow it.
  localparam int XLEN = 32;
  localparam int AW   = XLEN;
  localparam int DW   = XLEN;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_M0 = 2'd1,
    BUSY_M1 = 2'd2
  } arb_state_e;

  // Master index: M0 = data load/store port, M1 = instruction fetch port.
  typedef enum logic {
    MST_M0 = 1'b0,
    MST_M1 = 1'b1
  } mst_idx_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between the data (M0) and fetch (M1) masters.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller samples the grant only when it can issue.
// Ports: i_last_grant (round-robin build only), i_req0, i_req1 -> o_grant.
// Build option: ARB_RR_EN selects round-robin; otherwise M0 has fixed priority.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef ARB_RR_EN
  input  mst_idx_e i_last_grant,
`endif
  input  logic     i_req0,
  input  logic     i_req1,
  output mst_idx_e o_grant
);

  always_comb begin
    o_grant = MST_M0;
`ifdef ARB_RR_EN
    // On contention, hand the bus to whoever did not have it last.
    if (i_req0 && i_req1) begin
      o_grant = (i_last_grant == MST_M0) ? MST_M1 : MST_M0;
    end else if (i_req1) begin
      o_grant = MST_M1;
    end
`else
    // Data accesses stall the whole pipeline, so M0 always wins.
    if (!i_req0 && i_req1) begin
      o_grant = MST_M1;
    end
`endif
  end

endmodule

// File: rtl/mem_arb.sv
// Merges the core's data port (M0) and fetch port (M1) onto one memory port.
// Latency: request to mem_req 1 cycle; master ack is combinational from mem_ack.
// Backpressure: one outstanding access; masters hold req until their ack pulse.
// Ports: clk, reset_n; m0_* data master (rd/wr); m1_* fetch master (rd only);
//        mem_* slave port (req held until mem_ack).
// Build option: ARB_RR_EN enables round-robin arbitration (adds last_grant flop).
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW = mem_arb_pkg::AW,
  parameter int DW = mem_arb_pkg::DW
) (
  input  logic            clk,
  input  logic            reset_n,
  // data master
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [AW-1:0]   m0_addr,
  input  logic [DW-1:0]   m0_wdata,
  input  logic [DW/8-1:0] m0_be,
  output logic            m0_ack,
  output logic [DW-1:0]   m0_rdata,
  // instruction master
  input  logic            m1_req,
  input  logic [AW-1:0]   m1_addr,
  output logic            m1_ack,
  output logic [DW-1:0]   m1_rdata,
  // memory port
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ack,
  input  logic [DW-1:0]   mem_rdata
);

  arb_state_e      r_state;
  logic            r_mem_req;
  logic            r_mem_we;
  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [DW/8-1:0] r_mem_be;
  mst_idx_e        w_grant;
  logic            w_busy_m0;
  logic            w_busy_m1;

`ifdef ARB_RR_EN
  mst_idx_e        r_last_grant;
`endif

  mem_arb_pick u_pick (
`ifdef ARB_RR_EN
    .i_last_grant (r_last_grant),
`endif
    .i_req0       (m0_req),
    .i_req1       (m1_req),
    .o_grant      (w_grant)
  );

  // Grants are only issued from IDLE, so the cycle after every ack is
  // always an IDLE cycle and back-to-back grants never overlap an ack.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_be     <= '0;
`ifdef ARB_RR_EN
      r_last_grant <= MST_M1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (m0_req || m1_req) begin
            r_mem_req <= 1'b1;
            if (w_grant == MST_M1) begin
              // Fetch port is read-only and always full-word.
              r_state     <= BUSY_M1;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= m1_addr;
              r_mem_wdata <= '0;
              r_mem_be    <= '1;
            end else begin
              r_state     <= BUSY_M0;
              r_mem_we    <= m0_we;
              r_mem_addr  <= m0_addr;
              r_mem_wdata <= m0_wdata;
              r_mem_be    <= m0_be;
            end
`ifdef ARB_RR_EN
            r_last_grant <= w_grant;
`endif
          end
        end
        BUSY_M0, BUSY_M1: begin
          // Completion is driven by memory alone; a master dropping req
          // mid-access does not cancel it.
          if (mem_ack) begin
            r_state   <= IDLE;
            r_mem_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  assign w_busy_m0 = (r_state == BUSY_M0);
  assign w_busy_m1 = (r_state == BUSY_M1);

  // Responses route only to the granted master; mem_ack in IDLE goes nowhere.
  assign m0_ack   = w_busy_m0 & mem_ack;
  assign m1_ack   = w_busy_m1 & mem_ack;
  assign m0_rdata = w_busy_m0 ? mem_rdata : '0;
  assign m1_rdata = w_busy_m1 ? mem_rdata : '0;

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule
